// File: rtl/raifes_dm_hart_ctrl_pkg.sv
// Shared constants for the debug-module hart controller: debug ROM mailbox
// addresses, the EBREAK opcode, abstract-command error codes and FSM states.
package raifes_dm_hart_ctrl_pkg;

  localparam logic [31:0] ADDR_HART0_STATUS   = 32'h0000_0144;
  localparam logic [31:0] ADDR_HART0_POSTEXEC = 32'h0000_0148;
  localparam logic [31:0] ADDR_HART0_DATA0    = 32'h0000_014C;
  localparam logic [31:0] EBREAK              = 32'h0010_0073;
  localparam logic [4:0]  SCRATCH_REGNO       = 5'd28;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_HALTING, ST_RESUMING,
    ST_XARM, ST_XSTART, ST_XDONE,
    ST_PARM, ST_PSTART, ST_PDONE
  } dm_state_e;

  function automatic logic is_cmd_state(input dm_state_e s);
    return s inside {ST_XARM, ST_XSTART, ST_XDONE, ST_PARM, ST_PSTART, ST_PDONE};
  endfunction

endpackage

// File: rtl/raifes_dm_hart_ctrl_if.sv
// Debug ROM side of the hart controller: request lines, progbuf words and
// the snooped hart data-port write.
interface raifes_dm_hart_ctrl_if #(
  parameter int XPR_LEN = 32
);
  logic               debug_haltreq;
  logic               halted;
  logic               resume_ack;
  logic               resume_req;
  logic               postexec_req;
  logic [XPR_LEN-1:0] progbuf0;
  logic [XPR_LEN-1:0] progbuf1;
  logic [XPR_LEN-1:0] hart_addr;
  logic               hart_write;
  logic [XPR_LEN-1:0] hart_wdata;

  modport master (
    output debug_haltreq, resume_req, postexec_req, progbuf0, progbuf1,
    input  halted, resume_ack, hart_addr, hart_write, hart_wdata
  );

  modport slave (
    input  debug_haltreq, resume_req, postexec_req, progbuf0, progbuf1,
    output halted, resume_ack, hart_addr, hart_write, hart_wdata
  );
endinterface

// File: rtl/raifes_dm_insn_gen.sv
// Builds the single load/store that moves a GPR through the data0 mailbox:
// sw xN,0x14C(x0) for a read, lw xN,0x14C(x0) for a write.
module raifes_dm_insn_gen
  import raifes_dm_hart_ctrl_pkg::*;
#(
  parameter int XPR_LEN = 32
) (
  input  logic [4:0]         regno,
  input  logic               write,
  output logic [XPR_LEN-1:0] insn
);
  logic [31:0] insn32;

  always_comb begin
    if (write)
      insn32 = {ADDR_HART0_DATA0[11:0], 5'd0, 3'b010, regno, 7'h03};
    else
      insn32 = {ADDR_HART0_DATA0[11:5], regno, 5'd0, 3'b010, ADDR_HART0_DATA0[4:0], 7'h23};
  end

  assign insn = XPR_LEN'(insn32);
endmodule

// File: rtl/raifes_dm_hart_ctrl.sv
// Debug-module controller sequencing halt, resume and abstract commands
// (register transfer and/or user progbuf execution) through the debug ROM.
module raifes_dm_hart_ctrl
  import raifes_dm_hart_ctrl_pkg::*;
#(
  parameter int XPR_LEN   = 32,
  parameter int TIMEOUT_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dmi_haltreq,
  input  logic               dmi_resumereq,
  input  logic               cmd_valid,
  input  logic [4:0]         cmd_regno,
  input  logic [2:0]         cmd_size,
  input  logic               cmd_write,
  input  logic               cmd_transfer,
  input  logic               cmd_postexec,
  input  logic [2:0]         cmderr_clr,
  output logic               busy,
  output logic [2:0]         cmderr,
  input  logic               data0_we,
  input  logic [XPR_LEN-1:0] data0_wdata,
  output logic [XPR_LEN-1:0] data0,
  input  logic               pb_we,
  input  logic               pb_idx,
  input  logic [XPR_LEN-1:0] pb_wdata,
  output logic               allhalted,
  output logic               allresumeack,
  raifes_dm_hart_ctrl_if.master hart
);
  dm_state_e          state, state_n;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic               tmo;
  logic [4:0]         regno_q;
  logic               write_q, postexec_q;
  logic [XPR_LEN-1:0] user_pb [2];
  logic [XPR_LEN-1:0] xfer_insn;
  logic               wr_status, wr_postexec, wr_data0;
  logic               cmd_accept, err_set;
  cmderr_e            err_code;

  assign tmo         = &tmo_cnt;
  assign allhalted   = hart.halted;
  assign wr_status   = hart.hart_write && (hart.hart_addr == XPR_LEN'(ADDR_HART0_STATUS));
  assign wr_postexec = hart.hart_write && (hart.hart_addr == XPR_LEN'(ADDR_HART0_POSTEXEC));
  assign wr_data0    = hart.hart_write && (hart.hart_addr == XPR_LEN'(ADDR_HART0_DATA0));

  raifes_dm_insn_gen #(.XPR_LEN(XPR_LEN)) u_insn_gen (
    .regno (regno_q),
    .write (write_q),
    .insn  (xfer_insn)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    cmd_accept = 1'b0;
    err_set    = 1'b0;
    err_code   = CMDERR_NONE;
    if (cmd_valid && is_cmd_state(state) && cmderr == 3'(CMDERR_NONE)) begin
      err_set  = 1'b1;
      err_code = CMDERR_BUSY;
    end
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmderr == 3'(CMDERR_NONE)) begin
            if (!hart.halted) begin
              err_set  = 1'b1;
              err_code = CMDERR_HALTRESUME;
            end else if (cmd_transfer && (cmd_size != 3'd2 || cmd_regno == SCRATCH_REGNO)) begin
              err_set  = 1'b1;
              err_code = CMDERR_NOTSUP;
            end else begin
              cmd_accept = 1'b1;
              if (cmd_transfer)      state_n = ST_XARM;
              else if (cmd_postexec) state_n = ST_PARM;
            end
          end
        end else if (dmi_resumereq && hart.halted) begin
          state_n = ST_RESUMING;
        end else if (dmi_haltreq && !hart.halted) begin
          state_n = ST_HALTING;
        end
      end
      ST_HALTING:
        if (hart.halted || !dmi_haltreq || tmo) state_n = ST_IDLE;
      ST_RESUMING:
        if ((!hart.halted && hart.resume_ack) || tmo) state_n = ST_IDLE;
      ST_XARM: state_n = ST_XSTART;
      ST_PARM: state_n = ST_PSTART;
      ST_XSTART, ST_PSTART, ST_XDONE, ST_PDONE: begin
        // Losing halt mid-command means the progbuf trapped or the hart escaped.
        if (!hart.halted || tmo) begin
          err_set  = 1'b1;
          err_code = CMDERR_EXCEPTION;
          state_n  = ST_IDLE;
        end else if (state == ST_XSTART && wr_postexec) begin
          state_n = ST_XDONE;
        end else if (state == ST_PSTART && wr_postexec) begin
          state_n = ST_PDONE;
        end else if (state == ST_XDONE && wr_status) begin
          state_n = postexec_q ? ST_PARM : ST_IDLE;
        end else if (state == ST_PDONE && wr_status) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    hart.progbuf0 = user_pb[0];
    hart.progbuf1 = user_pb[1];
    if (state inside {ST_XARM, ST_XSTART, ST_XDONE}) begin
      hart.progbuf0 = xfer_insn;
      hart.progbuf1 = XPR_LEN'(EBREAK);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      tmo_cnt           <= TIMEOUT_W'(1);
      regno_q           <= '0;
      write_q           <= 1'b0;
      postexec_q        <= 1'b0;
      cmderr            <= 3'(CMDERR_NONE);
      data0             <= '0;
      allresumeack      <= 1'b0;
      busy              <= 1'b0;
      hart.debug_haltreq <= 1'b0;
      hart.resume_req   <= 1'b0;
      hart.postexec_req <= 1'b0;
      // NOTE: this two-word array is plain flops with a defined EBREAK reset; real RAMs are never reset.
      user_pb[0]        <= XPR_LEN'(EBREAK);
      user_pb[1]        <= XPR_LEN'(EBREAK);
    end else begin
      state <= state_n;
      // Reloading with 1 makes a watched state last exactly 2^TIMEOUT_W-1 cycles.
      tmo_cnt <= (state_n != state) ? TIMEOUT_W'(1) : tmo_cnt + TIMEOUT_W'(1);
      if (cmd_accept) begin
        regno_q    <= cmd_regno;
        write_q    <= cmd_write;
        postexec_q <= cmd_postexec;
      end
      cmderr <= err_set ? 3'(err_code) : (cmderr & ~cmderr_clr);
      if (wr_data0)             data0 <= hart.hart_wdata;
      else if (data0_we && !busy) data0 <= data0_wdata;
      if (pb_we && !busy) user_pb[pb_idx] <= pb_wdata;
      if (state == ST_IDLE && state_n == ST_RESUMING)
        allresumeack <= 1'b0;
      else if (state == ST_RESUMING && !hart.halted && hart.resume_ack)
        allresumeack <= 1'b1;
      // Requests are registered decodes of the next state, so they cannot glitch.
      busy               <= is_cmd_state(state_n);
      hart.debug_haltreq <= (state_n == ST_HALTING);
      hart.resume_req    <= (state_n == ST_RESUMING);
      hart.postexec_req  <= (state_n == ST_XARM) || (state_n == ST_PARM);
    end
  end
endmodule

// File: tb/tb_raifes_dm_hart_ctrl.sv
// Directed bench for raifes_dm_hart_ctrl: the bench plays the debug ROM and
// the DMI register file, with hand-computed expected values.
module tb_raifes_dm_hart_ctrl;
  localparam int XPR_LEN = 32;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;
  localparam logic [31:0] USER_W   = 32'h00A0_0093;

  logic clk = 1'b0;
  logic reset;
  logic dmi_haltreq, dmi_resumereq, cmd_valid;
  logic [4:0] cmd_regno;
  logic [2:0] cmd_size, cmderr_clr, cmderr;
  logic cmd_write, cmd_transfer, cmd_postexec, busy;
  logic data0_we, pb_we, pb_idx, allhalted, allresumeack;
  logic [XPR_LEN-1:0] data0_wdata, data0, pb_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int hi, n;

  raifes_dm_hart_ctrl_if #(.XPR_LEN(XPR_LEN)) hart_if ();

  raifes_dm_hart_ctrl #(.XPR_LEN(XPR_LEN), .TIMEOUT_W(10)) dut (
    .clk(clk), .reset(reset),
    .dmi_haltreq(dmi_haltreq), .dmi_resumereq(dmi_resumereq),
    .cmd_valid(cmd_valid), .cmd_regno(cmd_regno), .cmd_size(cmd_size),
    .cmd_write(cmd_write), .cmd_transfer(cmd_transfer), .cmd_postexec(cmd_postexec),
    .cmderr_clr(cmderr_clr), .busy(busy), .cmderr(cmderr),
    .data0_we(data0_we), .data0_wdata(data0_wdata), .data0(data0),
    .pb_we(pb_we), .pb_idx(pb_idx), .pb_wdata(pb_wdata),
    .allhalted(allhalted), .allresumeack(allresumeack),
    .hart(hart_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hart_wr(input logic [31:0] addr, input logic [31:0] wdata);
    hart_if.hart_addr  = addr;
    hart_if.hart_wdata = wdata;
    hart_if.hart_write = 1'b1;
    tick();
    hart_if.hart_write = 1'b0;
  endtask

  task automatic issue(input logic [4:0] regno, input logic [2:0] size, input logic wr,
                       input logic xfer, input logic pexec);
    cmd_regno = regno; cmd_size = size; cmd_write = wr;
    cmd_transfer = xfer; cmd_postexec = pexec; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic clear_err();
    cmderr_clr = 3'd7;
    tick();
    cmderr_clr = 3'd0;
  endtask

  initial begin
    reset = 1'b1; dmi_haltreq = 0; dmi_resumereq = 0; cmd_valid = 0;
    cmd_regno = 0; cmd_size = 0; cmd_write = 0; cmd_transfer = 0; cmd_postexec = 0;
    cmderr_clr = 0; data0_we = 0; data0_wdata = 0; pb_we = 0; pb_idx = 0; pb_wdata = 0;
    hart_if.halted = 0; hart_if.resume_ack = 0; hart_if.hart_addr = 0;
    hart_if.hart_write = 0; hart_if.hart_wdata = 0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_cmderr", 32'(cmderr), 0);
    check("rst_data0", data0, 0);
    check("rst_pb0", hart_if.progbuf0, EBREAK_W);
    check("rst_pb1", hart_if.progbuf1, EBREAK_W);
    check("rst_haltreq", 32'(hart_if.debug_haltreq), 0);
    check("rst_postexec", 32'(hart_if.postexec_req), 0);
    reset = 1'b0;

    // Halt: ROM raises halted after debug_haltreq has been high 5 cycles.
    dmi_haltreq = 1'b1;
    tick();
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (hart_if.debug_haltreq) hi++;
      if (hi == 5 && !hart_if.halted) hart_if.halted = 1'b1;
      if (hi > 0 && !hart_if.debug_haltreq) break;
      tick();
    end
    check("halt_cycles", 32'(hi), 5);
    check("halt_req_low", 32'(hart_if.debug_haltreq), 0);
    check("allhalted", 32'(allhalted), 1);
    dmi_haltreq = 1'b0;

    // Resume: ROM drops halted and acks after resume_req has been high 3 cycles.
    dmi_resumereq = 1'b1;
    tick();
    dmi_resumereq = 1'b0;
    check("resack_cleared", 32'(allresumeack), 0);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (hart_if.resume_req) hi++;
      if (hi == 3 && hart_if.halted) begin
        hart_if.halted = 1'b0;
        hart_if.resume_ack = 1'b1;
      end
      if (hi > 0 && !hart_if.resume_req) break;
      tick();
    end
    hart_if.resume_ack = 1'b0;
    check("resume_cycles", 32'(hi), 3);
    check("allresumeack", 32'(allresumeack), 1);
    check("allhalted_low", 32'(allhalted), 0);

    // Abstract read of x8.
    hart_if.halted = 1'b1;
    issue(5'd8, 3'd2, 1'b0, 1'b1, 1'b0);
    check("rd_busy", 32'(busy), 1);
    check("rd_postexec", 32'(hart_if.postexec_req), 1);
    check("rd_pb0", hart_if.progbuf0, 32'h1480_2623);
    check("rd_pb1", hart_if.progbuf1, EBREAK_W);
    tick();
    check("rd_postexec_pulse", 32'(hart_if.postexec_req), 0);
    hart_wr(32'h148, 32'h0);
    hart_wr(32'h14C, 32'hDEAD_BEEF);
    check("rd_data0", data0, 32'hDEAD_BEEF);
    check("rd_pb0_held", hart_if.progbuf0, 32'h1480_2623);
    hart_wr(32'h144, 32'h0);
    check("rd_done_busy", 32'(busy), 0);
    check("rd_cmderr", 32'(cmderr), 0);
    check("rd_idle_pb0", hart_if.progbuf0, EBREAK_W);

    // Abstract write of x8 followed by the user progbuf.
    data0_we = 1'b1; data0_wdata = 32'h1234;
    pb_we = 1'b1; pb_idx = 1'b0; pb_wdata = USER_W;
    tick();
    data0_we = 1'b0; pb_we = 1'b0;
    check("wr_data0", data0, 32'h1234);
    issue(5'd8, 3'd2, 1'b1, 1'b1, 1'b1);
    check("wr_pb0", hart_if.progbuf0, 32'h14C0_2403);
    check("wr_postexec1", 32'(hart_if.postexec_req), 1);
    tick();
    hart_wr(32'h148, 32'h0);
    hart_wr(32'h144, 32'h0);
    check("pe_postexec2", 32'(hart_if.postexec_req), 1);
    check("pe_pb0_user", hart_if.progbuf0, USER_W);
    check("pe_pb1_user", hart_if.progbuf1, EBREAK_W);
    check("pe_busy", 32'(busy), 1);
    tick();
    check("pe_pulse_end", 32'(hart_if.postexec_req), 0);
    hart_wr(32'h148, 32'h0);
    hart_wr(32'h144, 32'h0);
    check("pe_done_busy", 32'(busy), 0);
    check("pe_data0_kept", data0, 32'h1234);

    // Error codes.
    hart_if.halted = 1'b0;
    issue(5'd8, 3'd2, 1'b0, 1'b1, 1'b0);
    check("err_haltresume", 32'(cmderr), 4);
    check("err_no_busy", 32'(busy), 0);
    clear_err();
    check("err_clr1", 32'(cmderr), 0);
    hart_if.halted = 1'b1;
    issue(5'd28, 3'd2, 1'b0, 1'b1, 1'b0);
    check("err_x28", 32'(cmderr), 2);
    clear_err();
    issue(5'd8, 3'd3, 1'b0, 1'b1, 1'b0);
    check("err_size", 32'(cmderr), 2);
    clear_err();
    issue(5'd8, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    data0_we = 1'b1; data0_wdata = 32'h5555;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; data0_we = 1'b0;
    check("err_busy", 32'(cmderr), 1);
    check("busy_data0_ignored", data0, 32'h1234);
    hart_wr(32'h148, 32'h0);
    hart_wr(32'h144, 32'h0);
    check("err_busy_done", 32'(busy), 0);
    clear_err();
    check("err_clr2", 32'(cmderr), 0);

    // Timeout with no hart response.
    issue(5'd8, 3'd2, 1'b0, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (!busy) break;
      n++;
    end
    check("tmo_cycles", 32'(n), 1023);
    check("tmo_cmderr", 32'(cmderr), 3);
    check("tmo_busy", 32'(busy), 0);
    clear_err();

    // Reset in XDONE.
    issue(5'd8, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    hart_wr(32'h148, 32'h0);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_postexec", 32'(hart_if.postexec_req), 0);
    check("mid_rst_resreq", 32'(hart_if.resume_req), 0);
    check("mid_rst_pb0", hart_if.progbuf0, EBREAK_W);
    check("mid_rst_data0", data0, 0);
    check("mid_rst_resack", 32'(allresumeack), 0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/raifes_dm_hart_ctrl.md
Name: raifes_dm_hart_ctrl

Overview:
- Debug-module-side controller for the hart debug ROM's halt, resume and postexec handshake.
- Takes halt/resume requests and abstract commands (Access Register plus postexec) from the DMI register file.
- Drives haltreq, resume_req, postexec_req and the two progbuf words into the debug ROM.
- Snoops the hart data port to detect progbuf start/completion, and owns data0, which the hart's memory map serves at ADDR_HART0_DATA0 (0x14C).

Parameters:
XPR_LEN, 32, data/instruction width
TIMEOUT_W, 10, width of the hart-response timeout counter; timeout = 2^TIMEOUT_W-1 cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dmi_haltreq  in  1  dmcontrol.haltreq level
dmi_resumereq  in  1  dmcontrol.resumereq, 1-cycle pulse
cmd_valid  in  1  abstract command write strobe
cmd_regno  in  5  GPR index
cmd_size  in  3  aarsize
cmd_write  in  1  1 = debugger-to-GPR
cmd_transfer  in  1  perform register transfer
cmd_postexec  in  1  execute user progbuf afterwards
cmderr_clr  in  3  W1C mask for cmderr
busy  out  1  abstract command in progress
cmderr  out  3  sticky abstract command error
data0_we  in  1  debugger write of data0
data0_wdata  in  XPR_LEN  data0 write value
data0  out  XPR_LEN  data0 register
pb_we  in  1  user progbuf write
pb_idx  in  1  user progbuf slot
pb_wdata  in  XPR_LEN  user progbuf word
allhalted  out  1  mirror of hart halted
allresumeack  out  1  sticky, set on resume completion
debug_haltreq  out  1  debug interrupt to core
halted  in  1  from debug ROM
resume_ack  in  1  from debug ROM
resume_req  out  1  to debug ROM
postexec_req  out  1  1-cycle pulse to debug ROM
progbuf0  out  XPR_LEN  to debug ROM
progbuf1  out  XPR_LEN  to debug ROM
hart_addr  in  XPR_LEN  snooped hart data address
hart_write  in  1  snooped hart write strobe
hart_wdata  in  XPR_LEN  snooped hart write data

Behaviour:
- Reset values:
  - FSM = IDLE; all outputs 0 except progbuf0 = progbuf1 = user progbuf = 0x00100073 (EBREAK).
  - data0 = 0, cmderr = 0, allresumeack = 0.
- allhalted = halted (combinational).
- States: IDLE, HALTING, RESUMING, XARM, XSTART, XDONE, PARM, PSTART, PDONE.
- IDLE, priority order:
  1. cmd_valid
  2. dmi_resumereq with halted=1
  3. dmi_haltreq with halted=0
- HALTING:
  - debug_haltreq=1.
  - Leave to IDLE when halted=1, or when dmi_haltreq drops.
- RESUMING:
  - Entry clears allresumeack; resume_req=1.
  - Exit when halted=0 && resume_ack=1: set allresumeack, then IDLE.
  - dmi_resumereq while halted=0 is ignored.
- Command accept (cmd_valid in IDLE, with cmderr==0):
  - halted=0 -> cmderr=4, stay IDLE.
  - cmd_transfer && (cmd_size!=2 || regno==28) -> cmderr=2. x28 is the ROM scratch register.
  - cmd_transfer -> XARM; else cmd_postexec -> PARM; else no-op.
  - busy=1 from the next cycle until the return to IDLE.
- cmd_valid while busy or while cmderr!=0: cmderr busy case = 1 if cmderr==0; otherwise the command is ignored.
- Transfer progbuf words (XARM):
  - Read: progbuf0 = {7'h0A, regno, 5'd0, 3'b010, 5'h0C, 7'h23} (sw xN,0x14C(x0)).
  - Write: progbuf0 = {12'h14C, 5'd0, 3'b010, regno, 7'h03} (lw xN,0x14C(x0)).
  - progbuf1 = EBREAK.
- Transfer sequence:
  - XARM: pulse postexec_req for one cycle -> XSTART.
  - XSTART waits for hart_write to ADDR_HART0_POSTEXEC (0x148) -> XDONE.
  - XDONE waits for hart_write to ADDR_HART0_STATUS (0x144) -> PARM if cmd_postexec, else IDLE.
- Postexec sequence: PARM/PSTART/PDONE are identical, except progbuf0/1 = user progbuf.
- progbuf outputs:
  - Held stable from the arm state to the done state.
  - In IDLE they show the user progbuf.
- data0 capture:
  - A hart_write to 0x14C sets data0 <= hart_wdata, in any state.
  - The hart write wins over a simultaneous data0_we.
  - data0_we is ignored while busy.
- pb_we is ignored while busy.
- Timeout:
  - Counter reloads on every state change.
  - In HALTING/RESUMING/*START/*DONE, reaching all-ones -> IDLE.
  - Sets cmderr=3 in command states; resume/halt timeouts only return to IDLE.
- halted falling during *START/*DONE -> cmderr=3, IDLE.
- cmderr_clr clears the masked bits the same cycle; a new error on the same cycle wins.
- Reset mid-operation: all requests deassert the next cycle, with no glitch of postexec_req.

Decomposition:
- raifes_platform_constants.vh: ADDR_HART0_STATUS/STACK/POSTEXEC/DATA0, EBREAK opcode, cmderr codes, FSM state encodings.
- One sub-module, raifes_dm_insn_gen: combinational sw/lw synthesis from regno/write.

Test Plan:
- haltreq=1 with halted low; model ROM raises halted after 5 cycles -> debug_haltreq high exactly 5 cycles, then 0; allhalted=1.
- Halted, resumereq pulse; ROM drops halted and sets resume_ack after 3 cycles -> resume_req held 3 cycles, then 0; allresumeack=1.
- Read x8: progbuf0=0x14802623; snoop 0x148 write, then 0x14C write of 0xDEADBEEF, then 0x144 -> data0=0xDEADBEEF, busy falls, cmderr=0.
- Write x8 with data0=0x1234 and postexec: progbuf0=0x14C02403; after 0x144 a second postexec_req pulse fires; progbuf0 = user word.
- Command with halted=0 -> cmderr=4; regno=28 -> cmderr=2; cmd_valid while busy -> cmderr=1; cmderr_clr=7 -> 0.
- No hart response after postexec_req -> cmderr=3 after 1023 cycles, busy=0; reset asserted mid-XDONE -> all outputs at reset values next cycle.
